// File: rtl/prog_loader_ctrl.sv
// Purpose: parses a framed UART download (magic, length, payload, checksum) into instruction-RAM byte writes.
// Latency: a payload byte on rx_valid at cycle N appears as ram_we at N+1; load_done pulses at N+1 after the checksum byte.
// Backpressure: none; every rx_valid cycle is one byte and is always consumed.
module prog_loader_ctrl #(
    parameter int          ADDR_W  = 16,
    parameter logic [7:0]  MAGIC   = 8'hA5,
    parameter int          TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W-1:0] byte_cnt
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CHK    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [7:0]          chk_q, chk_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    // Helper values: incremented count, full length as it completes, running sum including this byte.
    logic [ADDR_W-1:0]   cnt_inc;
    logic [ADDR_W-1:0]   len_full;
    logic [7:0]          chk_sum;

    assign cnt_inc  = cnt_q + ADDR_W'(1);
    assign len_full = ADDR_W'({rx_data, len_q[7:0]});
    assign chk_sum  = chk_q + rx_data;

    // Frame parser: next state, datapath updates and registered output values.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        chk_d   = chk_q;
        tmr_d   = tmr_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        err_d   = err_q;

        // Inter-byte idle timer only runs while a frame is open.
        if (state_q != IDLE) begin
            if (rx_valid) begin
                tmr_d = '0;
            end else begin
                tmr_d = tmr_q + TMR_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (rx_valid && (rx_data == MAGIC)) begin
                    state_d = LEN_LO;
                    hold_d  = 1'b1;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    chk_d   = '0;
                end
            end
            LEN_LO: begin
                if (rx_valid) begin
                    len_d   = ADDR_W'(rx_data);
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (rx_valid) begin
                    len_d   = len_full;
                    state_d = (len_full == '0) ? CHK : DATA;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q;
                    wdata_d = rx_data;
                    cnt_d   = cnt_inc;
                    chk_d   = chk_sum;
                    if (cnt_inc == len_q) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (rx_valid) begin
                    if (chk_sum == 8'h00) begin
                        done_d = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        err_d  = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort an open frame after too long without a byte; an arriving byte always wins.
        if ((state_q != IDLE) && !rx_valid && (tmr_q == TMR_LAST)) begin
            err_d   = 1'b1;
            state_d = IDLE;
            tmr_d   = '0;
        end
    end

    // State and output registers; the CPU comes out of reset held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            chk_q   <= '0;
            tmr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            chk_q   <= chk_d;
            tmr_q   <= tmr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ram_we    = we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign cpu_hold  = hold_q;
    assign load_done = done_q;
    assign load_err  = err_q;
    assign byte_cnt  = cnt_q;

endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Bench for prog_loader_ctrl: directed frames plus randomized frames checked against a frame-level model.
// Short TIMEOUT so abort behaviour is reachable quickly.
// Inputs driven 1 time unit after the rising edge; outputs observed there or on the falling edge.
module tb_prog_loader_ctrl;

    localparam int         ADDR_W = 16;
    localparam logic [7:0] MAGIC  = 8'hA5;
    localparam int         TMO    = 40;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W-1:0] byte_cnt;

    prog_loader_ctrl #(.ADDR_W(ADDR_W), .MAGIC(MAGIC), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err),
        .byte_cnt  (byte_cnt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [23:0] wr_q[$];
    logic [23:0] exp_wr[$];
    int          done_cnt = 0;
    int          exp_done = 0;
    logic        exp_hold = 1'b1;
    logic        exp_err  = 1'b0;
    logic [15:0] exp_cnt  = 16'd0;

    // Capture every RAM write and done pulse seen on the outputs.
    always @(negedge clk) begin
        if (rst) begin
            if (ram_we) wr_q.push_back({ram_addr, ram_wdata});
            if (load_done) done_cnt++;
        end
    end

    // Frame-level reference: skip non-magic bytes, then consume magic/len/payload/checksum as a whole.
    task automatic model_stream(input logic [7:0] s[$]);
        int i;
        int len;
        int sum;
        i = 0;
        while (i < s.size()) begin
            if (s[i] != MAGIC) begin
                i++;
            end else begin
                len = int'(s[i+1]) + 256 * int'(s[i+2]);
                sum = 0;
                exp_err  = 1'b0;
                exp_hold = 1'b1;
                for (int k = 0; k < len; k++) begin
                    exp_wr.push_back({16'(k), s[i+3+k]});
                    sum += int'(s[i+3+k]);
                end
                if (((sum + int'(s[i+3+len])) % 256) == 0) begin
                    exp_done++;
                    exp_hold = 1'b0;
                end else begin
                    exp_err = 1'b1;
                end
                exp_cnt = 16'(len);
                i += len + 4;
            end
        end
    endtask

    task automatic prep(input logic [7:0] s[$]);
        wr_q.delete();
        exp_wr.delete();
        done_cnt = 0;
        exp_done = 0;
        model_stream(s);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_stream(input logic [7:0] s[$], input int unsigned maxgap);
        prep(s);
        foreach (s[i]) begin
            idle($urandom_range(maxgap, 0));
            send_byte(s[i]);
        end
        idle(3);
    endtask

    task automatic test_reset();
        rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        #12;
        n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_hold: got %b required 1", cpu_hold); end
        n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b required 0", ram_we); end
        n_checks++; if (ram_addr !== 16'h0 || ram_wdata !== 8'h0) begin n_fail++; $display("FAIL reset_addr_data: got %h/%h required 0/0", ram_addr, ram_wdata); end
        n_checks++; if (byte_cnt !== 16'h0 || load_done !== 1'b0 || load_err !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_flags: got %h/%b/%b required 0/0/0", byte_cnt, load_done, load_err); end
        rst = 1'b1;
        @(posedge clk); #1;
        prep('{});
        idle(3 * TMO);
        n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL idle_hold: got %b required 1", cpu_hold); end
        n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL idle_err: got %b required 0", load_err); end
        n_checks++; if (wr_q.size() !== 0 || done_cnt !== 0) begin n_fail++; $display("FAIL idle_activity: got %0d writes %0d done required 0 0", wr_q.size(), done_cnt); end
    endtask

    task automatic test_good_frame();
        logic [7:0] s[$];
        s = '{8'hA5, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hED};
        prep(s);
        for (int i = 0; i < 3; i++) send_byte(s[i]);
        n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL hdr_no_write: got %b required 0", ram_we); end
        send_byte(s[3]);
        n_checks++; if (ram_we !== 1'b1 || ram_addr !== 16'h0 || ram_wdata !== 8'h13) begin n_fail++; $display("FAIL write_latency: got we=%b addr=%h data=%h required 1/0000/13", ram_we, ram_addr, ram_wdata); end
        for (int i = 4; i < 7; i++) send_byte(s[i]);
        n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL done_early: got %b required 0", load_done); end
        send_byte(s[7]);
        n_checks++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL done_latency: got %b required 1", load_done); end
        idle(1);
        n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL done_pulse: got %b required 0", load_done); end
        idle(2);
        n_checks++; if (wr_q.size() !== exp_wr.size()) begin n_fail++; $display("FAIL good_nwr: got %0d required %0d", wr_q.size(), exp_wr.size()); end
        else foreach (exp_wr[j]) begin n_checks++; if (wr_q[j] !== exp_wr[j]) begin n_fail++; $display("FAIL good_wr%0d: got %h required %h", j, wr_q[j], exp_wr[j]); end end
        n_checks++; if (done_cnt !== exp_done) begin n_fail++; $display("FAIL good_done: got %0d required %0d", done_cnt, exp_done); end
        n_checks++; if (cpu_hold !== exp_hold || load_err !== exp_err) begin n_fail++; $display("FAIL good_flags: got hold=%b err=%b required %b %b", cpu_hold, load_err, exp_hold, exp_err); end
        n_checks++; if (byte_cnt !== exp_cnt) begin n_fail++; $display("FAIL good_cnt: got %h required %h", byte_cnt, exp_cnt); end
    endtask

    task automatic test_bad_checksum();
        run_stream('{8'hA5, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEE}, 1);
        n_checks++; if (wr_q.size() !== exp_wr.size()) begin n_fail++; $display("FAIL bad_nwr: got %0d required %0d", wr_q.size(), exp_wr.size()); end
        n_checks++; if (done_cnt !== 0 || exp_done !== 0) begin n_fail++; $display("FAIL bad_done: got %0d required 0", done_cnt); end
        n_checks++; if (load_err !== 1'b1 || cpu_hold !== 1'b1) begin n_fail++; $display("FAIL bad_flags: got err=%b hold=%b required 1 1", load_err, cpu_hold); end
        run_stream('{8'hA5, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hED}, 2);
        n_checks++; if (done_cnt !== exp_done) begin n_fail++; $display("FAIL recover_done: got %0d required %0d", done_cnt, exp_done); end
        n_checks++; if (load_err !== exp_err || cpu_hold !== exp_hold) begin n_fail++; $display("FAIL recover_flags: got err=%b hold=%b required %b %b", load_err, cpu_hold, exp_err, exp_hold); end
    endtask

    task automatic test_timeout();
        prep('{});
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h11);
        idle(TMO - 1);
        n_checks++; if (load_err !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got %b required 0", load_err); end
        idle(1);
        n_checks++; if (load_err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b required 1", load_err); end
        n_checks++; if (cpu_hold !== 1'b1 || byte_cnt !== 16'd1) begin n_fail++; $display("FAIL tmo_state: got hold=%b cnt=%h required 1 0001", cpu_hold, byte_cnt); end
        send_byte(8'h77);
        idle(2);
        n_checks++; if (wr_q.size() !== 1) begin n_fail++; $display("FAIL tmo_nwr: got %0d required 1", wr_q.size()); end
        else begin n_checks++; if (wr_q[0] !== 24'h000011) begin n_fail++; $display("FAIL tmo_wr: got %h required 000011", wr_q[0]); end end
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL tmo_done: got %0d required 0", done_cnt); end
        exp_err = 1'b1; exp_hold = 1'b1; exp_cnt = 16'd1;
    endtask

    task automatic test_timeout_boundary();
        prep('{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'hCD});
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00); send_byte(8'h11);
        idle(TMO - 1);
        send_byte(8'h22); send_byte(8'hCD);
        idle(3);
        n_checks++; if (wr_q.size() !== exp_wr.size()) begin n_fail++; $display("FAIL edge_nwr: got %0d required %0d", wr_q.size(), exp_wr.size()); end
        else foreach (exp_wr[j]) begin n_checks++; if (wr_q[j] !== exp_wr[j]) begin n_fail++; $display("FAIL edge_wr%0d: got %h required %h", j, wr_q[j], exp_wr[j]); end end
        n_checks++; if (done_cnt !== exp_done || load_err !== exp_err) begin n_fail++; $display("FAIL edge_done: got done=%0d err=%b required %0d %b", done_cnt, load_err, exp_done, exp_err); end
    endtask

    task automatic test_back_to_back();
        run_stream('{8'hA5, 8'h01, 8'h00, 8'hA5, 8'h5B}, 0);
        n_checks++; if (wr_q.size() !== exp_wr.size()) begin n_fail++; $display("FAIL b2b_nwr: got %0d required %0d", wr_q.size(), exp_wr.size()); end
        else foreach (exp_wr[j]) begin n_checks++; if (wr_q[j] !== exp_wr[j]) begin n_fail++; $display("FAIL b2b_wr%0d: got %h required %h", j, wr_q[j], exp_wr[j]); end end
        n_checks++; if (done_cnt !== exp_done || cpu_hold !== exp_hold) begin n_fail++; $display("FAIL b2b_done: got done=%0d hold=%b required %0d %b", done_cnt, cpu_hold, exp_done, exp_hold); end
        n_checks++; if (byte_cnt !== exp_cnt) begin n_fail++; $display("FAIL b2b_cnt: got %h required %h", byte_cnt, exp_cnt); end
    endtask

    task automatic test_zero_len();
        run_stream('{8'h12, 8'h34, 8'hA5, 8'h00, 8'h00, 8'h00}, 1);
        n_checks++; if (wr_q.size() !== 0) begin n_fail++; $display("FAIL zero_nwr: got %0d required 0", wr_q.size()); end
        n_checks++; if (done_cnt !== exp_done || cpu_hold !== exp_hold || load_err !== exp_err) begin n_fail++; $display("FAIL zero_flags: got done=%0d hold=%b err=%b required %0d %b %b", done_cnt, cpu_hold, load_err, exp_done, exp_hold, exp_err); end
        n_checks++; if (byte_cnt !== exp_cnt) begin n_fail++; $display("FAIL zero_cnt: got %h required %h", byte_cnt, exp_cnt); end
    endtask

    task automatic test_random();
        logic [7:0] s[$];
        logic [7:0] b;
        logic [7:0] sum;
        int         len;
        for (int f = 0; f < 20; f++) begin
            s.delete();
            repeat ($urandom_range(2, 0)) begin
                b = 8'($urandom_range(255, 0));
                if (b == MAGIC) b = 8'h00;
                s.push_back(b);
            end
            len = (f == 7) ? 260 : int'($urandom_range(8, 0));
            s.push_back(MAGIC);
            s.push_back(8'(len));
            s.push_back(8'(len >> 8));
            sum = 8'h00;
            for (int k = 0; k < len; k++) begin
                b = 8'($urandom);
                s.push_back(b);
                sum = sum + b;
            end
            b = 8'h00 - sum;
            if ($urandom_range(3, 0) == 0) b = b + 8'($urandom_range(255, 1));
            s.push_back(b);
            run_stream(s, 3);
            n_checks++; if (wr_q.size() !== exp_wr.size()) begin n_fail++; $display("FAIL rnd%0d_nwr: got %0d required %0d", f, wr_q.size(), exp_wr.size()); end
            else foreach (exp_wr[j]) begin n_checks++; if (wr_q[j] !== exp_wr[j]) begin n_fail++; $display("FAIL rnd%0d_wr%0d: got %h required %h", f, j, wr_q[j], exp_wr[j]); end end
            n_checks++; if (done_cnt !== exp_done) begin n_fail++; $display("FAIL rnd%0d_done: got %0d required %0d", f, done_cnt, exp_done); end
            n_checks++; if (cpu_hold !== exp_hold || load_err !== exp_err) begin n_fail++; $display("FAIL rnd%0d_flags: got hold=%b err=%b required %b %b", f, cpu_hold, load_err, exp_hold, exp_err); end
            n_checks++; if (byte_cnt !== exp_cnt) begin n_fail++; $display("FAIL rnd%0d_cnt: got %h required %h", f, byte_cnt, exp_cnt); end
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'hA5); send_byte(8'h05); send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (ram_we !== 1'b0 || byte_cnt !== 16'h0) begin n_fail++; $display("FAIL arst_we_cnt: got we=%b cnt=%h required 0 0000", ram_we, byte_cnt); end
        n_checks++; if (ram_addr !== 16'h0 || ram_wdata !== 8'h0) begin n_fail++; $display("FAIL arst_addr_data: got %h/%h required 0000/00", ram_addr, ram_wdata); end
        n_checks++; if (cpu_hold !== 1'b1 || load_err !== 1'b0 || load_done !== 1'b0) begin n_fail++; $display("FAIL arst_flags: got hold=%b err=%b done=%b required 1 0 0", cpu_hold, load_err, load_done); end
        idle(2);
        rst = 1'b1;
        idle(2);
        exp_hold = 1'b1; exp_err = 1'b0; exp_cnt = 16'd0;
        run_stream('{8'hA5, 8'h00, 8'h00, 8'h00}, 0);
        n_checks++; if (wr_q.size() !== 0 || done_cnt !== exp_done) begin n_fail++; $display("FAIL arst_restart: got %0d writes %0d done required 0 %0d", wr_q.size(), done_cnt, exp_done); end
        n_checks++; if (cpu_hold !== exp_hold) begin n_fail++; $display("FAIL arst_release: got %b required %b", cpu_hold, exp_hold); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_timeout();
        test_timeout_boundary();
        test_back_to_back();
        test_zero_len();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader_ctrl.md
Name: prog_loader_ctrl

Overview:
- Controller that sequences the instruction-RAM write port from the UART byte stream.
- Parses a framed download (magic, length, payload, checksum), generates the byte address, data and write strobe for the instruction RAM, and holds the CPU stalled until a valid program is loaded.
- Sits between the UART receiver and the IFU's RAM write port / pipeline hold input.

Parameters:
- ADDR_W, 16, width of the RAM byte address and of the length field.
- MAGIC, 8'hA5, frame start byte.
- TIMEOUT, 1000000, idle cycles allowed between bytes inside a frame before abort.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- rx_valid  input  1  one-cycle strobe: rx_data holds a new UART byte.
- rx_data  input  8  received byte.
- ram_we  output  1  instruction-RAM byte write strobe.
- ram_addr  output  ADDR_W  byte address for the write.
- ram_wdata  output  8  byte to write.
- cpu_hold  output  1  1 = CPU PC/pipeline held (no fetch advance).
- load_done  output  1  one-cycle pulse: frame accepted.
- load_err  output  1  sticky error flag (checksum or timeout).
- byte_cnt  output  ADDR_W  payload bytes written so far in the current frame.

Behaviour:
- Single clock domain. Async active-low reset; all registers respond immediately to rst=0.
- Reset values: ram_we=0, ram_addr=0, ram_wdata=0, cpu_hold=1, load_done=0, load_err=0, byte_cnt=0, state=IDLE, timer=0, checksum=0.
- rx_valid may assert on consecutive cycles. Each asserted cycle is exactly one byte.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CHK.
- IDLE:
  - rx_valid with rx_data==MAGIC: go to LEN_LO, set cpu_hold=1, clear load_err, byte_cnt and checksum.
  - Any other byte is ignored.
- LEN_LO: latch len[7:0] and go to LEN_HI.
- LEN_HI: latch len[15:8]. If len==0 go to CHK, otherwise go to DATA.
- DATA: each byte is written to RAM.
  - The cycle after rx_valid: ram_we=1 for exactly one cycle, ram_addr=byte_cnt (pre-increment value), ram_wdata=byte.
  - byte_cnt increments; checksum += byte, mod 256.
  - When the byte just accepted is byte number len (byte_cnt reaches len), go to CHK.
- CHK:
  - If (checksum + rx_data) mod 256 == 0: load_done pulses 1 cycle, cpu_hold=0, go to IDLE.
  - Otherwise: load_err=1, cpu_hold stays 1, go to IDLE.
- Timeout:
  - In any state other than IDLE, timer counts cycles with no rx_valid. rx_valid clears it.
  - When timer reaches TIMEOUT-1: load_err=1, cpu_hold stays 1, go to IDLE.
  - If rx_valid occurs on that same cycle, rx_valid wins: no timeout, byte processed.
- Address range: ram_addr never exceeds len-1. len max 65535, so no wrap.
- byte_cnt holds its final value in IDLE until the next MAGIC.
- A MAGIC value arriving in LEN/DATA/CHK is treated as ordinary data, not a restart.
- cpu_hold changes only on MAGIC acceptance, successful CHK, or reset.
- Write latency: rx_valid at cycle N gives ram_we at N+1. load_done appears at N+1 after the checksum byte.
- Reset mid-frame: all state returns to reset values; partially written RAM contents are left as-is.

Test Plan:
- Reset, no input -> cpu_hold=1, ram_we=0, load_err=0 indefinitely.
- Send A5,04,00,13,00,00,00,ED -> four ram_we pulses, addr 0..3, data 13,00,00,00; load_done pulse; cpu_hold=0; byte_cnt=4.
- Same frame with checksum byte EE -> load_err=1, cpu_hold=1, no load_done. A following correct frame clears load_err and releases hold.
- Send A5,02,00,11, then silence for TIMEOUT cycles -> load_err=1, state IDLE, only one ram_we issued (addr 0, data 11).
- Back-to-back rx_valid every cycle for A5,01,00,A5,5B -> one write of A5 at addr 0 (MAGIC taken as data), load_done.
- Zero-length frame A5,00,00,00 -> no ram_we, load_done, cpu_hold=0. Junk bytes 12,34 in IDLE before it are ignored.
- Assert rst=0 mid-DATA -> outputs return to reset values asynchronously, FSM restarts in IDLE.
